text_console_ctrl: RTL and testbench

//  Terminal sequencer in front of the Pixospark text memory (CPU region 0x4000-0x47FF).
//  - Accepts an ASCII byte stream on a valid/ready port.
//  - Tracks the cursor and interprets control codes.
//  - Issues single-byte text-memory writes, including clear-line and clear-screen sweeps.
//  - Schedules the shared write port: CPU writes always win; console writes use idle cycles.

---
 rtl/text_console_ctrl_pkg.sv | 26 ++
 rtl/text_console_ctrl_if.sv | 21 ++
 rtl/text_console_ctrl_cursor.sv | 63 ++++++
 rtl/text_console_ctrl.sv | 139 +++++++++++++
 tb/tb_text_console_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_ctrl_pkg.sv
// Shared types and constants for the text console sequencer.
// Holds the FSM state enum, ASCII control codes and geometry defaults.
package pw_console_pkg;

    localparam int COLS_DEF = 40;
    localparam int ROWS_DEF = 25;

    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_FF    = 8'h0C;
    localparam logic [7:0] ASC_BLANK = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLR_LINE,
        CLR_ALL,
        BS_WR
    } state_e;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character stream valid/ready handshake into the console.
// The source drives ChValid/ChData and holds them until ChReady.
interface text_console_ctrl_if;

    logic       ChValid;
    logic [7:0] ChData;
    logic       ChReady;

    modport master (
        output ChValid,
        output ChData,
        input  ChReady
    );

    modport slave (
        input  ChValid,
        input  ChData,
        output ChReady
    );

endinterface

// File: rtl/text_console_ctrl_cursor.sv
// Cursor column/row counters plus linear and row-base addresses.
// Addresses are stepped incrementally so no multiplier is needed.
module console_cursor
    import pw_console_pkg::*;
#(
    parameter  int COLS = COLS_DEF,
    parameter  int ROWS = ROWS_DEF,
    parameter  int AW   = 10,
    localparam int CW   = $clog2(COLS),
    localparam int RW   = $clog2(ROWS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          home_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          newline_i,
    input  logic          cr_i,
    output logic [CW-1:0] col_o,
    output logic [AW-1:0] adr_o,
    output logic [AW-1:0] base_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [AW-1:0] adr_q;
    logic [AW-1:0] base_q;
    logic          last_col;
    logic          last_row;
    logic [AW-1:0] base_d;

    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));
    assign base_d   = last_row ? '0 : base_q + AW'(COLS);

    always_ff @(posedge Clk) begin
        if (Reset || home_i) begin
            col_q  <= '0;
            row_q  <= '0;
            adr_q  <= '0;
            base_q <= '0;
        end else if (newline_i || (inc_i && last_col)) begin
            col_q  <= '0;
            row_q  <= last_row ? '0 : row_q + RW'(1);
            adr_q  <= base_d;
            base_q <= base_d;
        end else if (inc_i) begin
            col_q <= col_q + CW'(1);
            adr_q <= adr_q + AW'(1);
        end else if (dec_i) begin
            col_q <= col_q - CW'(1);
            adr_q <= adr_q - AW'(1);
        end else if (cr_i) begin
            col_q <= '0;
            adr_q <= base_q;
        end
    end

    assign col_o  = col_q;
    assign adr_o  = adr_q;
    assign base_o = base_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal sequencer: decodes a byte stream into text-memory writes.
// CPU writes own the shared port; console writes stall until it is free.
module text_console_ctrl
    import pw_console_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter int         AW    = 10,
    parameter logic [7:0] BLANK = ASC_BLANK
) (
    input  logic                Clk,
    input  logic                Reset,
    text_console_ctrl_if.slave  ch,
    input  logic                CpuWrt,
    input  logic [AW-1:0]       CpuAdr,
    input  logic [7:0]          CpuData,
    output logic                TxtWrt,
    output logic [AW-1:0]       TxtAdr,
    output logic [7:0]          TxtData,
    output logic [AW-1:0]       CursorAdr,
    output logic                Busy
);

    localparam int CW    = $clog2(COLS);
    localparam int NCELL = COLS * ROWS;

    state_e        state_q;
    logic [AW-1:0] sweep_q;
    logic [7:0]    char_q;

    logic          accept;
    logic          con_wr;
    logic          advance;
    logic          sweep_last;
    logic [AW-1:0] con_adr;
    logic [7:0]    con_data;
    logic [CW-1:0] cur_col;
    logic [AW-1:0] cur_adr;
    logic [AW-1:0] cur_base;
    logic          col_nz;
    logic          col_last;

    assign ch.ChReady = (state_q == IDLE) && !Reset;
    assign Busy       = (state_q != IDLE) || Reset;
    assign accept     = ch.ChValid && ch.ChReady;
    assign con_wr     = (state_q != IDLE);
    assign advance    = con_wr && !CpuWrt && !Reset;
    assign col_nz     = |cur_col;
    assign col_last   = (cur_col == CW'(COLS - 1));

    assign sweep_last = (state_q == CLR_ALL)
                      ? (sweep_q == AW'(NCELL - 1))
                      : (sweep_q == AW'(COLS - 1));

    always_comb begin
        con_adr  = cur_adr;
        con_data = BLANK;
        unique case (state_q)
            PUT:      con_data = char_q;
            CLR_LINE: con_adr  = cur_base + sweep_q;
            CLR_ALL:  con_adr  = sweep_q;
            default:  ;
        endcase
    end

    // CPU strobe wins the port; a pending console write simply waits
    assign TxtWrt  = !Reset && (CpuWrt || con_wr);
    assign TxtAdr  = CpuWrt ? CpuAdr  : con_adr;
    assign TxtData = CpuWrt ? CpuData : con_data;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .Clk       (Clk),
        .Reset     (Reset),
        .home_i    (advance && (state_q == CLR_ALL) && sweep_last),
        .inc_i     (advance && (state_q == PUT)),
        .dec_i     (accept && (ch.ChData == ASC_BS) && col_nz),
        .newline_i (accept && (ch.ChData == ASC_LF)),
        .cr_i      (accept && (ch.ChData == ASC_CR)),
        .col_o     (cur_col),
        .adr_o     (cur_adr),
        .base_o    (cur_base)
    );

    assign CursorAdr = cur_adr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLR_ALL;
            sweep_q <= '0;
            char_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        char_q  <= ch.ChData;
                        sweep_q <= '0;
                        unique case (1'b1)
                            is_print(ch.ChData):
                                state_q <= PUT;
                            (ch.ChData == ASC_LF):
                                state_q <= CLR_LINE;
                            (ch.ChData == ASC_BS) && col_nz:
                                state_q <= BS_WR;
                            (ch.ChData == ASC_FF):
                                state_q <= CLR_ALL;
                            default: ;
                        endcase
                    end
                end
                PUT: begin
                    if (advance) begin
                        state_q <= col_last ? CLR_LINE : IDLE;
                    end
                end
                CLR_LINE, CLR_ALL: begin
                    if (advance) begin
                        if (sweep_last) begin
                            state_q <= IDLE;
                            sweep_q <= '0;
                        end else begin
                            sweep_q <= sweep_q + AW'(1);
                        end
                    end
                end
                BS_WR: begin
                    if (advance) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl.
// A shadow memory captures every text-memory write for later inspection.
module tb_text_console_ctrl;

    logic       Clk;
    logic       Reset;
    logic       CpuWrt;
    logic [9:0] CpuAdr;
    logic [7:0] CpuData;
    logic       TxtWrt;
    logic [9:0] TxtAdr;
    logic [7:0] TxtData;
    logic [9:0] CursorAdr;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [7:0] mem [0:1023];

    text_console_ctrl_if ch_if ();

    text_console_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ch        (ch_if),
        .CpuWrt    (CpuWrt),
        .CpuAdr    (CpuAdr),
        .CpuData   (CpuData),
        .TxtWrt    (TxtWrt),
        .TxtAdr    (TxtAdr),
        .TxtData   (TxtData),
        .CursorAdr (CursorAdr),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (TxtWrt === 1'b1) begin
            mem[TxtAdr] = TxtData;
            wr_cnt++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Offer one byte; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        ch_if.ChValid = 1'b1;
        ch_if.ChData  = b;
        while (!ok && n < 3000) begin
            @(negedge Clk);
            ok = ch_if.ChReady;
            n++;
            step();
        end
        ch_if.ChValid = 1'b0;
        if (!ok) begin
            $display("FAIL send_timeout byte=%h got no ChReady, need ChReady=1", b);
            $fatal(1, "handshake timeout");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!ch_if.ChReady && n < 3000);
        step();
        if (n >= 3000) begin
            $display("FAIL idle_timeout got busy, need idle");
            $fatal(1, "idle timeout");
        end
    endtask

    task automatic cpu_fill(input int lo, input int hi, input logic [7:0] v);
        for (int a = lo; a <= hi; a++) begin
            CpuWrt  = 1'b1;
            CpuAdr  = 10'(a);
            CpuData = v;
            step();
        end
        CpuWrt = 1'b0;
    endtask

    task automatic test_reset();
        int n, exp_a, bad;
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b0 || ch_if.ChReady !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got wrt=%b rdy=%b busy=%b, need 0/0/1",
                     TxtWrt, ch_if.ChReady, Busy);
        end
        step();
        Reset = 1'b0;
        n = 0; exp_a = 0; bad = 0;
        do begin
            @(negedge Clk);
            n++;
            if (TxtWrt === 1'b1) begin
                if (TxtAdr !== 10'(exp_a) || TxtData !== 8'h20) bad++;
                exp_a++;
            end
        end while (ch_if.ChReady !== 1'b1 && n < 1200);
        step();
        checks++;
        if (exp_a != 1000 || bad != 0) begin
            errors++;
            $display("FAIL reset_clear got %0d writes %0d bad, need 1000 writes 0 bad",
                     exp_a, bad);
        end
        checks++;
        if (n != 1001) begin
            errors++;
            $display("FAIL reset_ready_cycle got %0d, need 1001", n);
        end
        checks++;
        if (CursorAdr !== 10'd0) begin
            errors++;
            $display("FAIL reset_cursor got %0d, need 0", CursorAdr);
        end
    endtask

    task automatic test_put();
        send(8'h41);
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b1 || TxtAdr !== 10'd0 || TxtData !== 8'h41
            || ch_if.ChReady !== 1'b0) begin
            errors++;
            $display("FAIL put_a got wrt=%b adr=%0d dat=%h rdy=%b, need 1/0/41/0",
                     TxtWrt, TxtAdr, TxtData, ch_if.ChReady);
        end
        step();
        send(8'h42);
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b1 || TxtAdr !== 10'd1 || TxtData !== 8'h42
            || ch_if.ChReady !== 1'b0) begin
            errors++;
            $display("FAIL put_b got wrt=%b adr=%0d dat=%h rdy=%b, need 1/1/42/0",
                     TxtWrt, TxtAdr, TxtData, ch_if.ChReady);
        end
        step();
        @(negedge Clk);
        checks++;
        if (CursorAdr !== 10'd2 || ch_if.ChReady !== 1'b1) begin
            errors++;
            $display("FAIL put_cursor got cur=%0d rdy=%b, need 2/1",
                     CursorAdr, ch_if.ChReady);
        end
        step();
    endtask

    task automatic test_line_wrap();
        int snap, bad;
        snap = wr_cnt;
        send(8'h0D);
        @(negedge Clk);
        step();
        checks++;
        if (CursorAdr !== 10'd0 || wr_cnt != snap) begin
            errors++;
            $display("FAIL cr got cur=%0d writes=%0d, need 0/0",
                     CursorAdr, wr_cnt - snap);
        end
        cpu_fill(40, 119, 8'h55);
        for (int i = 0; i < 40; i++) send(8'h78);
        send(8'h0A);
        wait_idle();
        bad = 0;
        for (int a = 0; a < 40; a++) if (mem[a] !== 8'h78) bad++;
        for (int a = 40; a < 120; a++) if (mem[a] !== 8'h20) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL line_fill got %0d bad cells in 0..119, need 0", bad);
        end
        checks++;
        if (CursorAdr !== 10'd80) begin
            errors++;
            $display("FAIL lf_cursor got %0d, need 80", CursorAdr);
        end
        for (int i = 0; i < 22; i++) send(8'h0A);
        wait_idle();
        checks++;
        if (CursorAdr !== 10'd960) begin
            errors++;
            $display("FAIL row24_cursor got %0d, need 960", CursorAdr);
        end
        cpu_fill(0, 39, 8'h55);
        for (int i = 0; i < 40; i++) send(8'h79);
        wait_idle();
        bad = 0;
        for (int a = 0; a < 40; a++) if (mem[a] !== 8'h20) bad++;
        for (int a = 960; a < 1000; a++) if (mem[a] !== 8'h79) bad++;
        checks++;
        if (bad != 0 || CursorAdr !== 10'd0) begin
            errors++;
            $display("FAIL last_cell_wrap got %0d bad cur=%0d, need 0 bad cur=0",
                     bad, CursorAdr);
        end
    endtask

    task automatic test_cpu_contention();
        int bad;
        send(8'h51);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            CpuWrt  = 1'b1;
            CpuAdr  = 10'd5;
            CpuData = 8'h7F;
            @(negedge Clk);
            if (TxtWrt !== 1'b1 || TxtAdr !== 10'd5 || TxtData !== 8'h7F
                || Busy !== 1'b1) bad++;
            step();
        end
        CpuWrt = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cpu_priority got %0d bad cycles, need 0", bad);
        end
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b1 || TxtAdr !== 10'd0 || TxtData !== 8'h51) begin
            errors++;
            $display("FAIL cpu_deferred got wrt=%b adr=%0d dat=%h, need 1/0/51",
                     TxtWrt, TxtAdr, TxtData);
        end
        step();
        @(negedge Clk);
        checks++;
        if (CursorAdr !== 10'd1 || ch_if.ChReady !== 1'b1) begin
            errors++;
            $display("FAIL cpu_after got cur=%0d rdy=%b, need 1/1",
                     CursorAdr, ch_if.ChReady);
        end
        step();
    endtask

    task automatic test_backspace();
        int snap;
        send(8'h0D);
        snap = wr_cnt;
        send(8'h08);
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b0 || CursorAdr !== 10'd0 || ch_if.ChReady !== 1'b1) begin
            errors++;
            $display("FAIL bs_col0 got wrt=%b cur=%0d rdy=%b, need 0/0/1",
                     TxtWrt, CursorAdr, ch_if.ChReady);
        end
        step();
        checks++;
        if (wr_cnt != snap) begin
            errors++;
            $display("FAIL bs_col0_writes got %0d, need 0", wr_cnt - snap);
        end
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h08);
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b1 || TxtAdr !== 10'd2 || TxtData !== 8'h20
            || CursorAdr !== 10'd2) begin
            errors++;
            $display("FAIL bs_write got wrt=%b adr=%0d dat=%h cur=%0d, need 1/2/20/2",
                     TxtWrt, TxtAdr, TxtData, CursorAdr);
        end
        step();
        wait_idle();
        checks++;
        if (mem[2] !== 8'h20 || mem[1] !== 8'h62 || CursorAdr !== 10'd2) begin
            errors++;
            $display("FAIL bs_mem got m2=%h m1=%h cur=%0d, need 20/62/2",
                     mem[2], mem[1], CursorAdr);
        end
    endtask

    task automatic test_form_feed();
        int snap;
        snap = wr_cnt;
        send(8'h0C);
        wait_idle();
        checks++;
        if (wr_cnt - snap != 1000 || CursorAdr !== 10'd0) begin
            errors++;
            $display("FAIL ff got %0d writes cur=%0d, need 1000/0",
                     wr_cnt - snap, CursorAdr);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n, exp_a, bad;
        send(8'h0A);
        repeat (4) begin
            @(negedge Clk);
            step();
        end
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b1 || TxtAdr !== 10'd44 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midsweep got wrt=%b adr=%0d busy=%b, need 1/44/1",
                     TxtWrt, TxtAdr, Busy);
        end
        step();
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (TxtWrt !== 1'b0 || ch_if.ChReady !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs got wrt=%b rdy=%b busy=%b, need 0/0/1",
                     TxtWrt, ch_if.ChReady, Busy);
        end
        step();
        Reset = 1'b0;
        checks++;
        if (CursorAdr !== 10'd0) begin
            errors++;
            $display("FAIL midreset_cursor got %0d, need 0", CursorAdr);
        end
        n = 0; exp_a = 0; bad = 0;
        do begin
            @(negedge Clk);
            n++;
            if (TxtWrt === 1'b1) begin
                if (TxtAdr !== 10'(exp_a) || TxtData !== 8'h20) bad++;
                exp_a++;
            end
        end while (ch_if.ChReady !== 1'b1 && n < 1200);
        step();
        checks++;
        if (exp_a != 1000 || bad != 0 || n != 1001) begin
            errors++;
            $display("FAIL midreset_clear got %0d writes %0d bad %0d cyc, need 1000/0/1001",
                     exp_a, bad, n);
        end
    endtask

    initial begin
        Reset         = 1'b1;
        CpuWrt        = 1'b0;
        CpuAdr        = '0;
        CpuData       = '0;
        ch_if.ChValid = 1'b0;
        ch_if.ChData  = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
        test_reset();
        test_put();
        test_line_wrap();
        test_cpu_contention();
        test_backspace();
        test_form_feed();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
